// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage (PC register, next-PC selection,
// blocking instruction-memory handshake, IF/ID pipeline buffer).
// Handles ID stall, EX redirect with flush, memory wait states, a one-entry
// hold buffer for responses landing during a stall, and squashing of a fetch
// that is still in flight when a redirect arrives.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   stall               ID cannot accept; IF/ID holds
//   redirect/_pc        taken branch or jump target from EX
//   inst_read/_addr     instruction-memory request (address stable until resp)
//   inst_rdata/_resp    instruction-memory response, one cycle per request
//   if_id_pc/_inst/_valid  IF/ID buffer
//
// Optional (define FETCH_PERF_CNT_EN): perf_fetched, perf_squashed, perf_wait.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0060),
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_read,
    output logic [XLEN-1:0] inst_addr,
    input  logic [XLEN-1:0] inst_rdata,
    input  logic            inst_resp,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_inst,
    output logic            if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_squashed,
    output logic [31:0]     perf_wait
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_SQUASH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] sq_addr_q, sq_addr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] hold_inst_q, hold_inst_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_inst_q, if_id_inst_d;
    logic            if_id_valid_q, if_id_valid_d;

    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] pc_inc;

    assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign pc_inc   = pc_q + XLEN'(PC_STEP);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (redirect)                state_d = inst_resp ? S_FETCH : S_SQUASH;
                else if (inst_resp && stall) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (redirect || !stall) state_d = S_FETCH;
            end
            S_SQUASH: begin
                // An in-flight response retires the squash; a concurrent
                // redirect only retargets pc.
                if (inst_resp) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Memory request outputs; SQUASH keeps the abandoned address on the bus
    // so the request stays stable until its response returns.
    always_comb begin
        inst_read = !reset && (state_q != S_HOLD);
        inst_addr = (state_q == S_SQUASH) ? sq_addr_q : pc_q;
    end

    // Datapath next-state
    always_comb begin
        pc_d          = pc_q;
        sq_addr_d     = sq_addr_q;
        hold_pc_d     = hold_pc_q;
        hold_inst_d   = hold_inst_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    pc_d          = redir_pc;
                    if_id_valid_d = 1'b0;
                    if (!inst_resp) sq_addr_d = pc_q;
                end else if (inst_resp) begin
                    pc_d = pc_inc;
                    if (!stall) begin
                        if_id_pc_d    = pc_q;
                        if_id_inst_d  = inst_rdata;
                        if_id_valid_d = 1'b1;
                    end else begin
                        hold_pc_d   = pc_q;
                        hold_inst_d = inst_rdata;
                    end
                end else if (!stall) begin
                    if_id_valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d          = redir_pc;
                    if_id_valid_d = 1'b0;
                end else if (!stall) begin
                    if_id_pc_d    = hold_pc_q;
                    if_id_inst_d  = hold_inst_q;
                    if_id_valid_d = 1'b1;
                end
            end
            S_SQUASH: begin
                if (redirect)           pc_d          = redir_pc;
                if (redirect || !stall) if_id_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            sq_addr_q     <= '0;
            hold_pc_q     <= '0;
            hold_inst_q   <= '0;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            sq_addr_q     <= sq_addr_d;
            hold_pc_q     <= hold_pc_d;
            hold_inst_q   <= hold_inst_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign if_id_pc    = if_id_pc_q;
    assign if_id_inst  = if_id_inst_q;
    assign if_id_valid = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic        fetched_c, squashed_c, wait_c;
    logic [31:0] perf_fetched_q, perf_squashed_q, perf_wait_q;

    // Event strobes mirroring the datapath decisions above
    always_comb begin
        fetched_c  = !redirect && !stall &&
                     (((state_q == S_FETCH) && inst_resp) || (state_q == S_HOLD));
        squashed_c = ((state_q == S_FETCH)  && redirect && inst_resp) ||
                     ((state_q == S_HOLD)   && redirect) ||
                     ((state_q == S_SQUASH) && inst_resp);
        wait_c     = inst_read && !inst_resp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
            perf_wait_q     <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_q  + 32'(fetched_c);
            perf_squashed_q <= perf_squashed_q + 32'(squashed_c);
            perf_wait_q     <= perf_wait_q     + 32'(wait_c);
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
    assign perf_wait     = perf_wait_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Memory returns addr ^ 32'hA5A5A5A5;
// response timing is driven per scenario.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_resp;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_squashed, perf_wait;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_read   (inst_read),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_resp   (inst_resp),
        .if_id_pc    (if_id_pc),
        .if_id_inst  (if_id_inst),
        .if_id_valid (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed),
        .perf_wait     (perf_wait)
`endif
    );

    always #5 clk = ~clk;

    always_comb inst_rdata = inst_addr ^ KEY;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_resp   = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_resp = 1'b1;
        step();
        n_cmp++; if (inst_read !== 1'b0) begin n_bad++; $display("FAIL reset_read got=%0b exp=0", inst_read); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", if_id_valid); end
        n_cmp++; if (if_id_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=0", if_id_pc); end
        n_cmp++; if (if_id_inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst got=%h exp=0", if_id_inst); end
    endtask

    task automatic test_sequential();
        do_reset();
        inst_resp = 1'b1;
        #1;
        n_cmp++; if (inst_addr !== 32'h60 || inst_read !== 1'b1) begin n_bad++; $display("FAIL seq_addr0 got=%h/%0b exp=60/1", inst_addr, inst_read); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL seq_valid0 got=%0b exp=0", if_id_valid); end
        step();
        n_cmp++; if (inst_addr !== 32'h64) begin n_bad++; $display("FAIL seq_addr1 got=%h exp=64", inst_addr); end
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h60 || if_id_inst !== (32'h60 ^ KEY))
            begin n_bad++; $display("FAIL seq_ifid1 got=%0b/%h/%h exp=1/60/%h", if_id_valid, if_id_pc, if_id_inst, 32'h60 ^ KEY); end
        step();
        n_cmp++; if (inst_addr !== 32'h68) begin n_bad++; $display("FAIL seq_addr2 got=%h exp=68", inst_addr); end
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h64) begin n_bad++; $display("FAIL seq_ifid2 got=%0b/%h exp=1/64", if_id_valid, if_id_pc); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (perf_fetched !== 32'd2) begin n_bad++; $display("FAIL perf_fetched got=%0d exp=2", perf_fetched); end
`endif
    endtask

    // Continues into hold, squash and hold-redirect scenarios without reset
    task automatic test_miss_hold_squash();
        do_reset();
        inst_resp = 1'b1;
        step();                                   // 0x60 accepted
        inst_resp = 1'b0;                         // miss cycle 1 at 0x64
        step();
        n_cmp++; if (inst_addr !== 32'h64 || if_id_valid !== 1'b0) begin n_bad++; $display("FAIL miss_c2 got=%h/%0b exp=64/0", inst_addr, if_id_valid); end
        step();
        n_cmp++; if (inst_addr !== 32'h64 || if_id_valid !== 1'b0) begin n_bad++; $display("FAIL miss_c3 got=%h/%0b exp=64/0", inst_addr, if_id_valid); end
        inst_resp = 1'b1;
        step();
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h64 || inst_addr !== 32'h68)
            begin n_bad++; $display("FAIL miss_done got=%0b/%h/%h exp=1/64/68", if_id_valid, if_id_pc, inst_addr); end

        // response for 0x68 while stalled
        stall = 1'b1;
        step();
        n_cmp++; if (inst_read !== 1'b0 || if_id_pc !== 32'h64 || if_id_valid !== 1'b1)
            begin n_bad++; $display("FAIL hold_c1 got=%0b/%h/%0b exp=0/64/1", inst_read, if_id_pc, if_id_valid); end
        inst_resp = 1'b0;
        step();
        n_cmp++; if (inst_read !== 1'b0 || if_id_pc !== 32'h64) begin n_bad++; $display("FAIL hold_c2 got=%0b/%h exp=0/64", inst_read, if_id_pc); end
        stall = 1'b0;
        step();
        n_cmp++; if (if_id_pc !== 32'h68 || if_id_inst !== (32'h68 ^ KEY) || if_id_valid !== 1'b1)
            begin n_bad++; $display("FAIL hold_release got=%h/%h/%0b exp=68/%h/1", if_id_pc, if_id_inst, if_id_valid, 32'h68 ^ KEY); end
        n_cmp++; if (inst_read !== 1'b1 || inst_addr !== 32'h6C) begin n_bad++; $display("FAIL hold_next got=%0b/%h exp=1/6c", inst_read, inst_addr); end

        // redirect while 0x70 is missing; low bits of the target are dropped
        inst_resp = 1'b1;
        step();                                   // 0x6C accepted, now at 0x70
        inst_resp = 1'b0; redirect = 1'b1; redirect_pc = 32'h201;
        step();
        redirect = 1'b0;
        n_cmp++; if (inst_addr !== 32'h70 || inst_read !== 1'b1 || if_id_valid !== 1'b0)
            begin n_bad++; $display("FAIL sq_c1 got=%h/%0b/%0b exp=70/1/0", inst_addr, inst_read, if_id_valid); end
        step();
        n_cmp++; if (inst_addr !== 32'h70) begin n_bad++; $display("FAIL sq_c2 got=%h exp=70", inst_addr); end
        inst_resp = 1'b1;                         // late response for 0x70
        step();
        n_cmp++; if (if_id_valid !== 1'b0 || if_id_pc === 32'h70) begin n_bad++; $display("FAIL sq_drop got=%0b/%h exp=0/not70", if_id_valid, if_id_pc); end
        n_cmp++; if (inst_addr !== 32'h200) begin n_bad++; $display("FAIL sq_target got=%h exp=200", inst_addr); end
        step();
        n_cmp++; if (if_id_pc !== 32'h200 || if_id_inst !== (32'h200 ^ KEY) || if_id_valid !== 1'b1)
            begin n_bad++; $display("FAIL sq_first got=%h/%h/%0b exp=200/%h/1", if_id_pc, if_id_inst, if_id_valid, 32'h200 ^ KEY); end

        // redirect to 0x300 while in HOLD and still stalled
        stall = 1'b1;
        step();                                   // 0x204 parked in hold
        n_cmp++; if (inst_read !== 1'b0) begin n_bad++; $display("FAIL hr_hold got=%0b exp=0", inst_read); end
        inst_resp = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        n_cmp++; if (if_id_valid !== 1'b0 || inst_addr !== 32'h300 || inst_read !== 1'b1)
            begin n_bad++; $display("FAIL hr_flush got=%0b/%h/%0b exp=0/300/1", if_id_valid, inst_addr, inst_read); end
        stall = 1'b0; inst_resp = 1'b1;
        step();
        n_cmp++; if (if_id_pc !== 32'h300 || if_id_valid !== 1'b1) begin n_bad++; $display("FAIL hr_next got=%h/%0b exp=300/1", if_id_pc, if_id_valid); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (perf_squashed !== 32'd2) begin n_bad++; $display("FAIL perf_squashed got=%0d exp=2", perf_squashed); end
`endif
    endtask

    // redirect coinciding with a response, then PC wrap at the top of memory
    task automatic test_wrap();
        do_reset();
        inst_resp = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        n_cmp++; if (inst_addr !== 32'hFFFF_FFFC || if_id_valid !== 1'b0 || inst_read !== 1'b1)
            begin n_bad++; $display("FAIL wrap_redir got=%h/%0b/%0b exp=fffffffc/0/1", inst_addr, if_id_valid, inst_read); end
        step();
        n_cmp++; if (if_id_pc !== 32'hFFFF_FFFC || if_id_valid !== 1'b1 || inst_addr !== 32'h0)
            begin n_bad++; $display("FAIL wrap got=%h/%0b/%h exp=fffffffc/1/0", if_id_pc, if_id_valid, inst_addr); end
    endtask

    task automatic test_async_reset();
        do_reset();
        inst_resp = 1'b1;
        step();                                   // 0x60 in IF/ID, 0x64 missing
        inst_resp = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || inst_read !== 1'b0)
            begin n_bad++; $display("FAIL areset_clear got=%0b/%h/%0b exp=0/0/0", if_id_valid, if_id_pc, inst_read); end
        inst_resp = 1'b1;                         // late response during reset
        step();
        reset = 1'b0; inst_resp = 1'b0;
        #1;
        n_cmp++; if (inst_addr !== 32'h60 || inst_read !== 1'b1 || if_id_valid !== 1'b0)
            begin n_bad++; $display("FAIL areset_restart got=%h/%0b/%0b exp=60/1/0", inst_addr, inst_read, if_id_valid); end
        inst_resp = 1'b1;
        step();
        n_cmp++; if (if_id_pc !== 32'h60 || if_id_valid !== 1'b1) begin n_bad++; $display("FAIL areset_first got=%h/%0b exp=60/1", if_id_pc, if_id_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_miss_hold_squash();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage: PC register, next-PC selection, blocking instruction-memory handshake and the IF/ID pipeline buffer.
- Adds to the basic always-load PC:
  - ID-stage stall
  - branch/jump redirect with flush
  - memory wait states
  - a one-entry hold buffer for responses that arrive while ID is stalled
  - squashing of an in-flight fetch when a redirect arrives.
- Sits between the instruction cache port and the decode stage.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h00000060, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  ID stage cannot accept a new instruction; IF/ID buffer holds.
- redirect  in  1  taken branch or jump resolved in EX (br_en & br_cw, or j_cw).
- redirect_pc  in  XLEN  redirect target; bits [1:0] forced to 0 internally.
- inst_read  out  1  instruction-memory read request.
- inst_addr  out  XLEN  instruction-memory address.
- inst_rdata  in  XLEN  instruction word, valid when inst_resp=1.
- inst_resp  in  1  memory response; one cycle per request.
- if_id_pc  out  XLEN  PC of the buffered instruction.
- if_id_inst  out  XLEN  buffered instruction.
- if_id_valid  out  1  buffered instruction is valid (0 = bubble).

Behaviour:
- Reset (asynchronous, any time, including mid-miss):
  - pc=RESET_PC, state=FETCH, hold cleared; if_id_pc/if_id_inst/if_id_valid=0.
  - inst_read=0 while reset is high.
  - Any outstanding memory response is ignored.
- Request rules:
  - inst_read=1 in FETCH and SQUASH, 0 in HOLD.
  - inst_addr: pc in FETCH; sq_addr (the abandoned address) in SQUASH; pc in HOLD (don't-care).
  - inst_addr is held stable until inst_resp.
- FETCH state, events in priority order:
  - redirect & inst_resp: drop data; pc<=redirect_pc; if_id_valid<=0; stay FETCH.
  - redirect & !inst_resp: sq_addr<=pc; pc<=redirect_pc; if_id_valid<=0; go SQUASH.
  - inst_resp & !stall: if_id<={pc,inst_rdata,1}; pc<=pc+PC_STEP; stay FETCH. Sustains 1 instruction per cycle on single-cycle hits.
  - inst_resp & stall: hold<={pc,inst_rdata}; pc<=pc+PC_STEP; IF/ID unchanged; go HOLD.
  - !inst_resp & !stall: if_id_valid<=0 (bubble); pc unchanged.
  - !inst_resp & stall: nothing changes.
- HOLD state:
  - redirect: discard hold; pc<=redirect_pc; if_id_valid<=0; go FETCH.
  - !stall: if_id<={hold_pc,hold_inst,1}; go FETCH; next request issues the following cycle.
  - stall: remain in HOLD.
- SQUASH state:
  - inst_resp: discard data; go FETCH, so the first request to pc (the redirect target) issues next cycle.
  - redirect: pc<=redirect_pc, stay SQUASH. Newest redirect wins.
  - if_id_valid<=0 whenever stall=0.
- Precedence: redirect overrides stall; the IF/ID buffer is flushed even while stalled.
- Arithmetic: pc+PC_STEP is XLEN-bit modulo, so 32'hFFFFFFFC+4 wraps to 0 with no flag.
- Instruction loss/duplication: no instruction is ever lost or duplicated. Every response is either written to IF/ID, parked in hold, or discarded because of a redirect.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds outputs:
  - perf_fetched (32): counts instructions written to IF/ID with valid=1.
  - perf_squashed (32): counts responses discarded due to redirect, including a held entry dropped in HOLD.
  - perf_wait (32): counts cycles with inst_read=1 & !inst_resp.
- Counters reset to 0 and wrap modulo 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, inst_resp tied 1 with inst_rdata=addr^32'hA5A5A5A5:
  - inst_addr sequence 0x60,0x64,0x68.
  - if_id_valid=1 from the 2nd cycle, if_id_pc trails inst_addr by 1 cycle.
- 3-cycle miss at 0x64 with stall=0:
  - inst_addr held at 0x64 for 3 cycles.
  - if_id_valid=0 for 2 cycles, then if_id_pc=0x64.
- Response for 0x68 arrives with stall=1, stall drops 2 cycles later:
  - state HOLD, inst_read=0, IF/ID stays 0x64.
  - After release, if_id_pc=0x68; next request is 0x6C.
- Redirect to 0x200 while 0x70 is missing:
  - inst_addr stays 0x70 until inst_resp; that data is never seen on IF/ID.
  - Next request is 0x200; if_id_valid=0 the cycle after the redirect.
- Redirect to 0x300 with stall=1 while in HOLD:
  - if_id_valid=0 next cycle; held entry discarded.
  - Next inst_addr is 0x300.
- reset pulsed mid-miss, not aligned to clk:
  - Outputs clear immediately.
  - The late inst_resp is ignored; the first request after release is 0x60.
